// File: rtl/codec_cfg_sequencer_pkg.sv
// codec_cfg_pkg: shared definitions for the codec configuration sequencer.
//  - reg word layout {reg_addr[6:0], value[8:0]} and index/state widths
//  - FSM state encodings (plain constants so older tools and checkers bind easily)
//  - WM8731-style register addresses and a helper that packs a reg word
package codec_cfg_pkg;

  localparam int REG_ADDR_W = 7;
  localparam int VALUE_W    = 9;
  localparam int WORD_W     = REG_ADDR_W + VALUE_W;
  localparam int INDEX_W    = 6;
  localparam int STATE_W    = 4;

  localparam logic [STATE_W-1:0] ST_IDLE     = 4'd0;
  localparam logic [STATE_W-1:0] ST_LOAD     = 4'd1;
  localparam logic [STATE_W-1:0] ST_GAP      = 4'd2;
  localparam logic [STATE_W-1:0] ST_ARM      = 4'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_LOW = 4'd4;
  localparam logic [STATE_W-1:0] ST_WAIT_END = 4'd5;
  localparam logic [STATE_W-1:0] ST_CHECK    = 4'd6;
  localparam logic [STATE_W-1:0] ST_NEXT     = 4'd7;
  localparam logic [STATE_W-1:0] ST_HOST     = 4'd8;
  localparam logic [STATE_W-1:0] ST_FIN      = 4'd9;

  localparam logic [REG_ADDR_W-1:0] REG_LLINE_IN = 7'h00;
  localparam logic [REG_ADDR_W-1:0] REG_RLINE_IN = 7'h01;
  localparam logic [REG_ADDR_W-1:0] REG_LHP_OUT  = 7'h02;
  localparam logic [REG_ADDR_W-1:0] REG_RHP_OUT  = 7'h03;
  localparam logic [REG_ADDR_W-1:0] REG_ANA_PATH = 7'h04;
  localparam logic [REG_ADDR_W-1:0] REG_DIG_PATH = 7'h05;
  localparam logic [REG_ADDR_W-1:0] REG_PWR_DOWN = 7'h06;
  localparam logic [REG_ADDR_W-1:0] REG_DIG_FMT  = 7'h07;
  localparam logic [REG_ADDR_W-1:0] REG_SAMPLING = 7'h08;
  localparam logic [REG_ADDR_W-1:0] REG_ACTIVE   = 7'h09;
  localparam logic [REG_ADDR_W-1:0] REG_RESET    = 7'h0F;

  function automatic logic [WORD_W-1:0] reg_word(input logic [REG_ADDR_W-1:0] addr,
                                                 input logic [VALUE_W-1:0] value);
    return {addr, value};
  endfunction

endpackage

// File: rtl/codec_cfg_sequencer_if.sv
// codec_cfg_sequencer_if: handshake bundle between the sequencer, the host and the
// 24-bit I2C writer.
//  HOST_REQ/HOST_DATA/HOST_GNT : host write request
//  I2C_DATA/GO/END/ACK         : I2C writer transfer
// Handshake semantics:
//  - Host: HOST_REQ is held high with HOST_DATA stable until a HOST_GNT pulse; the
//    cycle HOST_GNT is high is the cycle HOST_DATA is latched.
//  - Writer: GO rising starts a transfer of I2C_DATA, which stays stable while GO is
//    high. The writer drops END while busy and raises it when finished; ACK is only
//    meaningful while END=1 (1 = NACK). GO must go low before the next transfer.
// Modports: master = sequencer side, slave = host/writer side.
interface codec_cfg_sequencer_if;
  import codec_cfg_pkg::*;

  logic              HOST_REQ;
  logic [WORD_W-1:0] HOST_DATA;
  logic              HOST_GNT;
  logic [23:0]       I2C_DATA;
  logic              GO;
  logic              END;
  logic              ACK;

  modport master (input HOST_REQ, HOST_DATA, END, ACK,
                  output HOST_GNT, I2C_DATA, GO);
  modport slave  (output HOST_REQ, HOST_DATA, END, ACK,
                  input HOST_GNT, I2C_DATA, GO);
endinterface

// File: rtl/codec_cfg_sequencer_rom.sv
// codec_cfg_rom: fixed codec init table, combinational.
//  index in [5:0]  -> word out [15:0] = {reg_addr[6:0], value[8:0]}
//  Indices past the end of the table read as 16'h0000.
module codec_cfg_rom
  import codec_cfg_pkg::*;
(
  input  logic [INDEX_W-1:0] index,
  output logic [WORD_W-1:0]  word
);

  always_comb begin
    word = '0;
    case (index)
      6'd0:    word = reg_word(REG_RESET,    9'h000);  // soft reset first
      6'd1:    word = reg_word(REG_LLINE_IN, 9'h017);  // 0 dB, unmuted
      6'd2:    word = reg_word(REG_RLINE_IN, 9'h017);
      6'd3:    word = reg_word(REG_LHP_OUT,  9'h079);  // 0 dB headphone
      6'd4:    word = reg_word(REG_RHP_OUT,  9'h079);
      6'd5:    word = reg_word(REG_ANA_PATH, 9'h012);  // DAC select, line in
      6'd6:    word = reg_word(REG_DIG_PATH, 9'h000);
      6'd7:    word = reg_word(REG_PWR_DOWN, 9'h000);  // everything powered
      6'd8:    word = reg_word(REG_DIG_FMT,  9'h042);  // master, I2S 16-bit
      6'd9:    word = reg_word(REG_SAMPLING, 9'h000);
      6'd10:   word = reg_word(REG_ACTIVE,   9'h001);  // activate last
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: walks the codec register table through the 24-bit I2C writer
// after reset or START, retries NACKed/timed-out entries, then serves host writes.
// Ports:
//  CLOCK      in  I2C bit clock (shared with the writer)
//  RESET      in  synchronous, active low
//  START      in  1-cycle pulse, (re)run the table; ignored while busy
//  bus        master modport: host request/grant and writer GO/END/ACK/I2C_DATA
//  BUSY       out table or host write in progress
//  DONE       out table finished with no fatal entry (sticky until START)
//  ERROR      out some write exhausted its retries (sticky until START)
//  CUR_INDEX  out table index in progress, or first fatally failed index
//  dbg_state  out current FSM state
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int          NUM_REGS   = 11,
  parameter logic [7:0]  SLAVE_ADDR = 8'h34,
  parameter int          MAX_RETRY  = 3,
  parameter int          TIMEOUT    = 63,
  parameter int          GAP_CYCLES = 4,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  START,
  codec_cfg_sequencer_if.master bus,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR,
  output logic [INDEX_W-1:0]    CUR_INDEX,
  output logic [STATE_W-1:0]    dbg_state
);

  localparam logic [INDEX_W-1:0] LAST_IDX  = INDEX_W'(NUM_REGS - 1);
  localparam logic [5:0]         TMO_LIMIT = 6'(TIMEOUT);
  localparam logic [5:0]         GAP_LAST  = 6'(GAP_CYCLES - 1);
  localparam logic [2:0]         RETRY_MAX = 3'(MAX_RETRY);

  logic [STATE_W-1:0] state;
  logic [5:0]         cnt;        // gap length, then cycles since GO rose
  logic [2:0]         retry;
  logic [INDEX_W-1:0] ptr;        // table pointer; keeps advancing after a fatal entry
  logic               table_mode; // 1: running the table, 0: single host write
  logic               load_pend;  // post-reset holdoff must end in LOAD, not ARM
  logic               tmo;
  logic               go;
  logic               host_gnt;
  logic [23:0]        i2c_data;
  logic [WORD_W-1:0]  rom_word;

  codec_cfg_rom u_rom (
    .index (ptr),
    .word  (rom_word)
  );

  assign bus.GO       = go;
  assign bus.I2C_DATA = i2c_data;
  assign bus.HOST_GNT = host_gnt;
  assign dbg_state    = state;

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state      <= AUTO_START ? ST_GAP : ST_IDLE;
      load_pend  <= AUTO_START;
      table_mode <= AUTO_START;
      cnt        <= '0;
      retry      <= '0;
      ptr        <= '0;
      tmo        <= 1'b0;
      go         <= 1'b0;
      host_gnt   <= 1'b0;
      i2c_data   <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
      CUR_INDEX  <= '0;
    end else begin
      host_gnt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state      <= ST_LOAD;
            ptr        <= '0;
            table_mode <= 1'b1;
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
            CUR_INDEX  <= '0;
          end else if (bus.HOST_REQ) begin
            state      <= ST_HOST;
            table_mode <= 1'b0;
            host_gnt   <= 1'b1;
            BUSY       <= 1'b1;
          end
        end
        ST_HOST: begin
          i2c_data <= {SLAVE_ADDR, bus.HOST_DATA};
          cnt      <= '0;
          state    <= ST_GAP;
        end
        ST_LOAD: begin
          i2c_data  <= {SLAVE_ADDR, rom_word};
          load_pend <= 1'b0;
          BUSY      <= 1'b1;
          // Once an entry has failed fatally, CUR_INDEX keeps reporting it.
          if (!ERROR) CUR_INDEX <= ptr;
          cnt       <= '0;
          state     <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (load_pend) begin
              state <= ST_LOAD;
            end else begin
              go    <= 1'b1;
              state <= ST_ARM;
            end
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ST_ARM: begin
          cnt   <= 6'd1;
          tmo   <= 1'b0;
          state <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW, ST_WAIT_END: begin
          // Timeout has priority over a writer event seen on the same cycle.
          if (cnt == TMO_LIMIT) begin
            tmo   <= 1'b1;
            state <= ST_CHECK;
          end else begin
            cnt <= cnt + 6'd1;
            if (state == ST_WAIT_LOW && !bus.END) state <= ST_WAIT_END;
            if (state == ST_WAIT_END && bus.END)  state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          go <= 1'b0;
          if (!tmo && bus.END && !bus.ACK) begin
            state <= ST_NEXT;
          end else if (retry < RETRY_MAX) begin
            retry <= retry + 3'd1;
            cnt   <= '0;
            state <= ST_GAP;   // same I2C_DATA is resent
          end else begin
            ERROR <= 1'b1;
            state <= ST_NEXT;  // give up on this entry, keep walking the table
          end
        end
        ST_NEXT: begin
          retry <= '0;
          if (!table_mode || ptr == LAST_IDX) begin
            state <= ST_FIN;
          end else begin
            ptr   <= ptr + 6'd1;
            state <= ST_LOAD;
          end
        end
        ST_FIN: begin
          if (table_mode && !ERROR) DONE <= 1'b1;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
module tb_codec_cfg_sequencer;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_GAP      = 4'd2;
  localparam logic [3:0] S_WAIT_END = 4'd5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic       busy, done, error;
  logic [5:0] cur_index;
  logic [3:0] dbg_state;

  codec_cfg_sequencer_if bus ();

  codec_cfg_sequencer #(
    .NUM_REGS   (11),
    .SLAVE_ADDR (8'h34),
    .MAX_RETRY  (3),
    .TIMEOUT    (63),
    .GAP_CYCLES (4),
    .AUTO_START (1'b1)
  ) dut (
    .CLOCK     (clk),
    .RESET     (rst_n),
    .START     (start),
    .bus       (bus),
    .BUSY      (busy),
    .DONE      (done),
    .ERROR     (error),
    .CUR_INDEX (cur_index),
    .dbg_state (dbg_state)
  );

  // Hand-written WM8731 init words {addr[6:0], value[8:0]}.
  logic [15:0] rom_words [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                  16'h0812, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1000,
                                  16'h1201};

  int vectors     = 0;
  int miscompares = 0;

  logic [23:0] xfer_q[$];
  logic [23:0] exp_q[$];

  // ---------------- I2C writer model + bus monitor ----------------
  bit          stuck     = 1'b0;
  bit          w_busy    = 1'b0;
  bit          w_nack    = 1'b0;
  int          w_cnt     = 0;
  logic [15:0] nack_word = 16'hFFFF;
  int          nack_left = 0;
  logic        go_prev   = 1'b0;
  logic [23:0] data_prev = '0;
  int          go_rises  = 0;
  int          cur_w     = 0;
  int          last_w    = 0;
  int          unstable  = 0;

  always @(negedge clk) begin
    if (stuck) begin
      bus.END = 1'b1;
      bus.ACK = 1'b0;
      w_busy  = 1'b0;
    end else if (w_busy && !bus.GO) begin
      w_busy  = 1'b0;           // aborted by the sequencer
      bus.END = 1'b1;
    end else if (w_busy) begin
      if (w_cnt == 0) begin
        bus.END = 1'b1;
        bus.ACK = w_nack;
        w_busy  = 1'b0;
      end else begin
        w_cnt--;
      end
    end else if (bus.GO && !go_prev) begin
      xfer_q.push_back(bus.I2C_DATA);
      w_busy  = 1'b1;
      w_cnt   = 8;
      bus.END = 1'b0;
      w_nack  = (bus.I2C_DATA[15:0] == nack_word) && (nack_left > 0);
      if (w_nack) nack_left--;
    end
    if (bus.GO && !go_prev) go_rises++;
    if (bus.GO && go_prev && bus.I2C_DATA !== data_prev) unstable++;
    if (bus.GO) cur_w++;
    else if (cur_w != 0) begin
      last_w = cur_w;
      cur_w  = 0;
    end
    go_prev   = bus.GO;
    data_prev = bus.I2C_DATA;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dbg_state == S_IDLE && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic push_table(input int rep_idx, input int extra);
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back({8'h34, rom_words[i]});
      if (i == rep_idx) repeat (extra) exp_q.push_back({8'h34, rom_words[i]});
    end
  endtask

  task automatic check_log(input string tag);
    logic [23:0] e;
    logic [23:0] got;
    check({tag, "_count"}, 32'(xfer_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (xfer_q.size() > 0) got = xfer_q.pop_front();
      else got = 'x;
      check(tag, 32'(got), 32'(e));
    end
    xfer_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit got_gnt;
    int rises0;
    bit hit;

    bus.END       = 1'b1;
    bus.ACK       = 1'b0;
    bus.HOST_REQ  = 1'b0;
    bus.HOST_DATA = '0;

    // Reset values (AUTO_START parks in GAP)
    cycles(3);
    check("rst_go",        32'(bus.GO),       32'd0);
    check("rst_i2c_data",  32'(bus.I2C_DATA), 32'd0);
    check("rst_host_gnt",  32'(bus.HOST_GNT), 32'd0);
    check("rst_busy",      32'(busy),         32'd0);
    check("rst_done",      32'(done),         32'd0);
    check("rst_error",     32'(error),        32'd0);
    check("rst_cur_index", 32'(cur_index),    32'd0);
    check("rst_state",     32'(dbg_state),    32'(S_GAP));

    // Auto start on reset release, all entries ACKed
    rst_n = 1'b1;
    wait_idle("auto", 2000);
    push_table(-1, 0);
    check_log("auto_xfer");
    check("auto_done",      32'(done),      32'd1);
    check("auto_error",     32'(error),     32'd0);
    check("auto_cur_index", 32'(cur_index), 32'd10);

    // Entry 3 NACKs twice then ACKs; a START mid-table is ignored
    nack_word = 16'h0479;
    nack_left = 2;
    pulse_start();
    check("retry_busy_set",   32'(busy), 32'd1);
    check("retry_done_clear", 32'(done), 32'd0);
    cycles(30);
    pulse_start();
    wait_idle("retry", 2000);
    push_table(3, 2);
    check_log("retry_xfer");
    check("retry_done",      32'(done),      32'd1);
    check("retry_error",     32'(error),     32'd0);
    check("retry_cur_index", 32'(cur_index), 32'd10);

    // Entry 5 always NACKs: 4 attempts, ERROR, index frozen, rest still sent
    nack_word = 16'h0812;
    nack_left = 1000;
    pulse_start();
    wait_idle("fatal", 2000);
    push_table(5, 3);
    check_log("fatal_xfer");
    check("fatal_error",     32'(error),     32'd1);
    check("fatal_done",      32'(done),      32'd0);
    check("fatal_cur_index", 32'(cur_index), 32'd5);

    // START and HOST_REQ together: table first, grant only after it finishes
    nack_left     = 0;
    bus.HOST_DATA = 16'h0C00;
    bus.HOST_REQ  = 1'b1;
    pulse_start();
    got_gnt = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.HOST_GNT) begin
        got_gnt = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("host_gnt_seen",    32'(got_gnt),       32'd1);
    check("host_gnt_after11", 32'(xfer_q.size()), 32'd11);
    check("host_gnt_done",    32'(done),          32'd1);
    bus.HOST_REQ = 1'b0;
    @(negedge clk);
    check("host_gnt_pulse",   32'(bus.HOST_GNT),  32'd0);
    wait_idle("host", 2000);
    push_table(-1, 0);
    exp_q.push_back(24'h340C00);
    check_log("host_xfer");
    check("host_i2c_data",  32'(bus.I2C_DATA), 32'h340C00);
    check("host_done",      32'(done),         32'd1);
    check("host_error",     32'(error),        32'd0);
    check("host_cur_index", 32'(cur_index),    32'd10);

    // Writer END stuck high: every attempt times out
    stuck  = 1'b1;
    rises0 = go_rises;
    pulse_start();
    wait_idle("stuck", 6000);
    check("stuck_attempts",  32'(go_rises - rises0), 32'd44);
    check("stuck_go_width",  32'(last_w),            32'd65);
    check("stuck_error",     32'(error),             32'd1);
    check("stuck_done",      32'(done),              32'd0);
    check("stuck_cur_index", 32'(cur_index),         32'd0);
    stuck = 1'b0;
    xfer_q.delete();

    // Reset during WAIT_END drops GO/BUSY next edge, release restarts at index 0
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (dbg_state == S_WAIT_END) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rstmid_reached", 32'(hit), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_go",    32'(bus.GO), 32'd0);
    check("rstmid_busy",  32'(busy),   32'd0);
    check("rstmid_error", 32'(error),  32'd0);
    rst_n = 1'b1;
    xfer_q.delete();
    wait_idle("restart", 2000);
    push_table(-1, 0);
    check_log("restart_xfer");
    check("restart_done", 32'(done), 32'd1);

    check("data_stable_while_go", 32'(unstable), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
